// File: rtl/arm_mc_sequencer_if.sv
`default_nettype none
// ============================================================================
// arm_mc_sequencer_if : fetch, decode-sideband and data-memory bundle of the
//                       multi-cycle sequencer
// Revision 1.0
// ============================================================================
interface arm_mc_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic [31:0]       inst_in;
    logic              inst_ready;
    logic              cond_pass;
    logic              is_mem_op;
    logic              is_store;
    logic              set_flags;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              mem_ready;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst_reg;
    logic              mem_req;
    logic              mem_write_en;
    logic              rd_we_gate;
    logic              cpsr_we_gate;
    logic              halted;
    logic              timeout_err;
    logic [CNT_W-1:0]  retired;
    logic [2:0]        state;

    // The sequencer is the master: it issues the requests and the gates.
    modport master (
        input  inst_in, inst_ready, cond_pass, is_mem_op, is_store,
               set_flags, branch_taken, branch_target, mem_ready,
        output inst_req, inst_addr, inst_reg, mem_req, mem_write_en,
               rd_we_gate, cpsr_we_gate, halted, timeout_err, retired, state
    );

    modport slave (
        output inst_in, inst_ready, cond_pass, is_mem_op, is_store,
               set_flags, branch_taken, branch_target, mem_ready,
        input  inst_req, inst_addr, inst_reg, mem_req, mem_write_en,
               rd_we_gate, cpsr_we_gate, halted, timeout_err, retired, state
    );
endinterface
`default_nettype wire

// File: rtl/arm_mc_sequencer.sv
`default_nettype none
// ============================================================================
// arm_mc_sequencer : FETCH/DECODE/EXEC/MEM/WB control sequencer with memory
//                    ready handshakes, stall timeout and retire counter
// Revision 1.0
// ============================================================================
module arm_mc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       HALT_INST = 32'he3a000bb,
    parameter int                MAX_WAIT  = 15,
    parameter int                CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    arm_mc_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic              r_halted;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_retired;
    logic [7:0]        r_wait;

    logic [ADDR_W-1:0] w_pc_seq;
    logic [ADDR_W-1:0] w_pc_branch;
    logic [CNT_W-1:0]  w_retired_inc;
    logic              w_stall_timeout;

    assign w_pc_seq        = r_pc + ADDR_W'(4);
    assign w_pc_branch     = bus.branch_target & ~ADDR_W'(3);
    assign w_retired_inc   = (r_retired == '1) ? r_retired : r_retired + CNT_W'(1);
    assign w_stall_timeout = (r_wait == c_max_wait);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_inst    <= '0;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_retired <= '0;
            r_wait    <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.inst_ready) begin
                        r_inst <= bus.inst_in;
                        r_wait <= '0;
                        if (bus.inst_in == HALT_INST) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= S_DECODE;
                        end
                    end else if (w_stall_timeout) begin
                        r_state   <= S_ERR;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_DECODE: r_state <= S_EXEC;
                S_EXEC: begin
                    // A failed condition retires the instruction as a no-op.
                    if (!bus.cond_pass) begin
                        r_pc      <= w_pc_seq;
                        r_retired <= w_retired_inc;
                        r_state   <= S_FETCH;
                    end else if (bus.is_mem_op) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    // Ready on the final permitted stall still completes the access.
                    if (bus.mem_ready) begin
                        r_wait  <= '0;
                        r_state <= S_WB;
                    end else if (w_stall_timeout) begin
                        r_state   <= S_ERR;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_WB: begin
                    r_pc      <= bus.branch_taken ? w_pc_branch : w_pc_seq;
                    r_retired <= w_retired_inc;
                    r_state   <= S_FETCH;
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign bus.inst_req     = (r_state == S_FETCH);
    assign bus.inst_addr    = r_pc;
    assign bus.inst_reg     = r_inst;
    assign bus.mem_req      = (r_state == S_MEM);
    assign bus.mem_write_en = (r_state == S_MEM) && bus.is_store;
    assign bus.rd_we_gate   = (r_state == S_WB) && (!bus.is_store || !bus.is_mem_op);
    assign bus.cpsr_we_gate = (r_state == S_WB) && bus.set_flags;
    assign bus.halted       = r_halted;
    assign bus.timeout_err  = r_timeout;
    assign bus.retired      = r_retired;
    assign bus.state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_arm_mc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_arm_mc_sequencer : directed self-checking bench for arm_mc_sequencer
// Revision 1.0
// ============================================================================
module tb_arm_mc_sequencer;

    localparam int          ADDR_W = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] HALT   = 32'he3a000bb;
    localparam logic [31:0] NOP    = 32'he1a00000;

    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2,
                           MEM = 3'd3, WB = 3'd4, HALTS = 3'd5, ERR = 3'd6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt;

    arm_mc_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    arm_mc_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h100),
        .HALT_INST(HALT),
        .MAX_WAIT (15),
        .CNT_W    (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.inst_in       = NOP;
        bus.inst_ready    = 1'b1;
        bus.cond_pass     = 1'b1;
        bus.is_mem_op     = 1'b0;
        bus.is_store      = 1'b0;
        bus.set_flags     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.mem_ready     = 1'b0;

        tick; tick;
        chk("rst_state",   bus.state, FETCH);
        chk("rst_ireq",    bus.inst_req, 1);
        chk("rst_addr",    bus.inst_addr, 32'h100);
        chk("rst_ireg",    bus.inst_reg, 0);
        chk("rst_retired", bus.retired, 0);
        chk("rst_flags",   {bus.halted, bus.timeout_err}, 0);
        chk("rst_gates",   {bus.mem_req, bus.mem_write_en, bus.rd_we_gate, bus.cpsr_we_gate}, 0);
        rst = 1'b1;

        // Three NOPs, one FETCH every four cycles.
        for (int i = 0; i < 3; i++) begin
            bus.inst_in = NOP + 32'(i);
            chk("nop_fetch", bus.state, FETCH);
            chk("nop_addr",  bus.inst_addr, 32'h100 + 32'(4 * i));
            tick; chk("nop_dec", bus.state, DECODE);
            chk("nop_ireg", bus.inst_reg, NOP + 32'(i));
            tick; chk("nop_exec", bus.state, EXEC);
            tick; chk("nop_wb", {bus.state, bus.rd_we_gate, bus.cpsr_we_gate}, {WB, 2'b10});
            tick;
        end
        chk("nop3_addr",    bus.inst_addr, 32'h10c);
        chk("nop3_retired", bus.retired, 3);

        // Load, mem_ready on the fourth MEM cycle.
        bus.is_mem_op = 1'b1;
        tick; tick; tick;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.state != MEM) break;
            if (bus.mem_req) cnt++;
            chk("ld_wen", bus.mem_write_en, 0);
            bus.mem_ready = (cnt == 4);
            tick;
        end
        bus.mem_ready = 1'b0;
        chk("ld_memreq_cycles", cnt, 4);
        chk("ld_wb", {bus.state, bus.rd_we_gate, bus.mem_req}, {WB, 2'b10});
        tick;
        chk("ld_len_addr", {bus.state, bus.inst_addr}, {FETCH, 32'h110});

        // Store with immediate mem_ready.
        bus.is_store  = 1'b1;
        bus.mem_ready = 1'b1;
        tick; tick; tick;
        chk("st_mem", {bus.state, bus.mem_req, bus.mem_write_en}, {MEM, 2'b11});
        tick;
        chk("st_wb", {bus.state, bus.rd_we_gate, bus.mem_write_en}, {WB, 2'b00});
        tick;
        chk("st_next", {bus.state, bus.inst_addr}, {FETCH, 32'h114});
        chk("st_retired", bus.retired, 5);

        // Condition-failed instruction.
        bus.is_store = 1'b0; bus.is_mem_op = 1'b0; bus.mem_ready = 1'b0;
        bus.cond_pass = 1'b0; bus.set_flags = 1'b1;
        tick; tick;
        chk("cf_exec_gates", {bus.state, bus.rd_we_gate, bus.cpsr_we_gate, bus.mem_req}, {EXEC, 3'b000});
        tick;
        chk("cf_next", {bus.state, bus.inst_addr}, {FETCH, 32'h118});
        chk("cf_retired", bus.retired, 6);

        // Branch to 0x2003 aligns to 0x2000.
        bus.cond_pass = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h2003;
        tick; tick; tick;
        chk("br_wb", {bus.state, bus.rd_we_gate, bus.cpsr_we_gate}, {WB, 2'b11});
        tick;
        chk("br_addr", bus.inst_addr, 32'h2000);
        bus.set_flags = 1'b0; bus.branch_target = 32'hffffffff;
        tick; tick; tick; tick;
        chk("br_top", bus.inst_addr, 32'hfffffffc);
        bus.branch_taken = 1'b0;
        tick; tick; tick; tick;
        chk("pc_wrap", {bus.state, bus.inst_addr}, {FETCH, 32'h0});
        chk("wrap_retired", bus.retired, 9);

        // Load whose ready arrives on the last permitted stall cycle.
        bus.is_mem_op = 1'b1;
        tick; tick; tick;
        for (int k = 0; k < 15; k++) tick;
        chk("edge_still_mem", {bus.state, bus.timeout_err}, {MEM, 1'b0});
        bus.mem_ready = 1'b1;
        tick;
        bus.mem_ready = 1'b0;
        chk("edge_ready_wins", {bus.state, bus.timeout_err}, {WB, 1'b0});
        tick;
        chk("edge_next", bus.inst_addr, 32'h4);

        // Fetch stall, then condition-failed memory op skips MEM.
        bus.inst_ready = 1'b0;
        tick; tick;
        chk("fstall", {bus.state, bus.inst_req}, {FETCH, 1'b1});
        bus.inst_ready = 1'b1; bus.cond_pass = 1'b0;
        tick; tick; tick;
        chk("cf_mem_skip", {bus.state, bus.inst_addr}, {FETCH, 32'h8});
        chk("cf_mem_retired", bus.retired, 11);

        // Retire counter saturates at 15.
        for (int i = 0; i < 6; i++) begin
            tick; tick; tick;
        end
        chk("sat_retired", bus.retired, 15);
        chk("sat_addr", bus.inst_addr, 32'h20);

        // Data-memory timeout.
        bus.cond_pass = 1'b1;
        tick; tick; tick;
        for (int k = 0; k < 15; k++) tick;
        chk("tmo_before", {bus.state, bus.timeout_err}, {MEM, 1'b0});
        tick;
        chk("tmo_err", {bus.state, bus.timeout_err, bus.mem_req, bus.inst_req}, {ERR, 3'b100});
        for (int k = 0; k < 5; k++) tick;
        chk("tmo_frozen", {bus.state, bus.inst_addr, 28'd0, bus.retired}, {ERR, 32'h20, 28'd0, 4'd15});

        rst = 1'b0;
        tick;
        rst = 1'b1;
        chk("rst2", {bus.state, bus.timeout_err, bus.inst_addr}, {FETCH, 1'b0, 32'h100});
        chk("rst2_retired", bus.retired, 0);

        // Halt instruction.
        bus.inst_in = HALT; bus.is_mem_op = 1'b0;
        tick;
        chk("halt", {bus.state, bus.halted, bus.inst_addr}, {HALTS, 1'b1, 32'h100});
        chk("halt_ireg", bus.inst_reg, HALT);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.inst_req || !bus.halted) cnt++;
            tick;
        end
        chk("halt_hold", cnt, 0);
        chk("halt_retired", bus.retired, 0);

        bus.inst_in = NOP;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        chk("rst3", {bus.state, bus.halted, bus.inst_req, bus.inst_addr}, {FETCH, 2'b01, 32'h100});
        tick;
        chk("rst3_refetch", bus.state, DECODE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
